// File: rtl/shf_pkg.sv
// Shared definitions for the shifter-unit controller: group/class codes,
// instruction field positions and the pipeline stage record.
package shf_pkg;

   localparam int SHF_DATASIZE = 16;
   localparam int SHF_RADDR    = 4;

   localparam logic [1:0] SHF_GRP = 2'b10;

   typedef enum logic [1:0] {
      SHF_CLS_LSH   = 2'b00,
      SHF_CLS_ROT   = 2'b01,
      SHF_CLS_LEFTZ = 2'b10,
      SHF_CLS_LEFTO = 2'b11
   } shf_cls_e;

   localparam int SHF_GRP_LSB = 14;
   localparam int SHF_CLS_LSB = 12;
   localparam int SHF_RN_LSB  = 8;
   localparam int SHF_RX_LSB  = 4;
   localparam int SHF_RY_LSB  = 0;

   typedef struct packed {
      logic                 valid;
      shf_cls_e             cls;
      logic [SHF_RADDR-1:0] rn;
      logic [SHF_RADDR-1:0] rx;
      logic [SHF_RADDR-1:0] ry;
   } shf_stage_t;

   // LEFTZ/LEFTO are single-operand; only the two shift classes read Ry.
   function automatic logic cls_uses_ry(input shf_cls_e cls);
      return (cls[1] == 1'b0);
   endfunction

endpackage

// File: rtl/shf_ctl_if.sv
// Bundle of sequencer-side and shifter-side signals of the shifter controller;
// master = instruction source / shifter environment, slave = shf_ctl.
interface shf_ctl_if;
   import shf_pkg::*;

   logic                 ps_ins_vld;
   logic [15:0]          ps_ins;
   logic                 shc_ps_rdy;
   logic                 ps_astat_clr;
   logic                 ps_shf_en;
   logic [1:0]           ps_shf_cls;
   logic [SHF_RADDR-1:0] shc_rf_rxa;
   logic [SHF_RADDR-1:0] shc_rf_rya;
   logic                 shc_rf_we;
   logic [SHF_RADDR-1:0] shc_rf_wa;
   logic                 shf_ps_sv;
   logic                 shf_ps_sz;
   logic                 shc_astat_sv;
   logic                 shc_astat_sz;
   logic                 shc_astat_svs;
   logic                 shc_ill;

   modport master (
      output ps_ins_vld, ps_ins, ps_astat_clr, shf_ps_sv, shf_ps_sz,
      input  shc_ps_rdy, ps_shf_en, ps_shf_cls, shc_rf_rxa, shc_rf_rya,
             shc_rf_we, shc_rf_wa, shc_astat_sv, shc_astat_sz, shc_astat_svs, shc_ill
   );

   modport slave (
      input  ps_ins_vld, ps_ins, ps_astat_clr, shf_ps_sv, shf_ps_sz,
      output shc_ps_rdy, ps_shf_en, ps_shf_cls, shc_rf_rxa, shc_rf_rya,
             shc_rf_we, shc_rf_wa, shc_astat_sv, shc_astat_sz, shc_astat_svs, shc_ill
   );

endinterface

// File: rtl/shf_ins_dec.sv
// Combinational shifter-instruction decoder: field extraction, group check
// and whether the class reads the Ry operand.
module shf_ins_dec
   import shf_pkg::*;
(
   input  logic [15:0]          ins,
   output logic                 is_shf,
   output logic                 uses_ry,
   output shf_cls_e             cls,
   output logic [SHF_RADDR-1:0] rn,
   output logic [SHF_RADDR-1:0] rx,
   output logic [SHF_RADDR-1:0] ry
);

   assign is_shf  = (ins[SHF_GRP_LSB +: 2] == SHF_GRP);
   assign cls     = shf_cls_e'(ins[SHF_CLS_LSB +: 2]);
   assign uses_ry = cls_uses_ry(cls);
   assign rn      = ins[SHF_RN_LSB +: SHF_RADDR];
   assign rx      = ins[SHF_RX_LSB +: SHF_RADDR];
   assign ry      = ins[SHF_RY_LSB +: SHF_RADDR];

endmodule

// File: rtl/shf_ctl.sv
// Shifter controller: ISSUE/WB pipeline with one-cycle RAW stall and ASTAT capture.
// Optional sticky overflow flag enabled by defining SHF_STICKY_EN.
module shf_ctl
   import shf_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   shf_ctl_if.slave  bus
);

   logic                 dec_is_shf_s;
   logic                 dec_uses_ry_s;
   shf_cls_e             dec_cls_s;
   logic [SHF_RADDR-1:0] dec_rn_s;
   logic [SHF_RADDR-1:0] dec_rx_s;
   logic [SHF_RADDR-1:0] dec_ry_s;

   logic                 hazard_s;
   logic                 rdy_s;
   logic                 accept_s;
   shf_stage_t           iss_next_s;

   shf_stage_t           iss_r;
   logic                 we_r;
   logic [SHF_RADDR-1:0] wa_r;
   logic                 ill_r;
   logic                 astat_sz_r;
   logic                 astat_sv_r;

   shf_ins_dec u_dec (
      .ins     (bus.ps_ins),
      .is_shf  (dec_is_shf_s),
      .uses_ry (dec_uses_ry_s),
      .cls     (dec_cls_s),
      .rn      (dec_rn_s),
      .rx      (dec_rx_s),
      .ry      (dec_ry_s)
   );

   // RAW hazard against the ISSUE-stage producer only; WB writes land before the re-read.
   always_comb begin
      hazard_s = 1'b0;
      if (bus.ps_ins_vld && dec_is_shf_s && iss_r.valid) begin
         hazard_s = (dec_rx_s == iss_r.rn) || (dec_uses_ry_s && (dec_ry_s == iss_r.rn));
      end else begin
         hazard_s = 1'b0;
      end
   end

   assign rdy_s    = reset && !hazard_s;
   assign accept_s = bus.ps_ins_vld && rdy_s;

   // Next ISSUE contents; unused Ry address is presented as zero.
   always_comb begin
      iss_next_s = '0;
      if (accept_s && dec_is_shf_s) begin
         iss_next_s.valid = 1'b1;
         iss_next_s.cls   = dec_cls_s;
         iss_next_s.rn    = dec_rn_s;
         iss_next_s.rx    = dec_rx_s;
         iss_next_s.ry    = dec_uses_ry_s ? dec_ry_s : {SHF_RADDR{1'b0}};
      end else begin
         iss_next_s = '0;
      end
   end

   // Pipeline registers; reset drops anything in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         iss_r <= '0;
         we_r  <= 1'b0;
         wa_r  <= {SHF_RADDR{1'b0}};
         ill_r <= 1'b0;
      end else begin
         iss_r <= iss_next_s;
         we_r  <= iss_r.valid;
         wa_r  <= iss_r.valid ? iss_r.rn : {SHF_RADDR{1'b0}};
         ill_r <= accept_s && !dec_is_shf_s;
      end
   end

   // ASTAT flags capture the shifter result flags at the end of each WB cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         astat_sz_r <= 1'b0;
         astat_sv_r <= 1'b0;
      end else if (we_r) begin
         astat_sz_r <= bus.shf_ps_sz;
         astat_sv_r <= bus.shf_ps_sv;
      end else begin
         astat_sz_r <= astat_sz_r;
         astat_sv_r <= astat_sv_r;
      end
   end

`ifdef SHF_STICKY_EN
   logic astat_svs_r;

   // Sticky overflow: a WB overflow takes priority over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         astat_svs_r <= 1'b0;
      end else if (we_r && bus.shf_ps_sv) begin
         astat_svs_r <= 1'b1;
      end else if (bus.ps_astat_clr) begin
         astat_svs_r <= 1'b0;
      end else begin
         astat_svs_r <= astat_svs_r;
      end
   end

   assign bus.shc_astat_svs = astat_svs_r;
`else
   logic unused_clr_s;
   assign unused_clr_s      = bus.ps_astat_clr;
   assign bus.shc_astat_svs = 1'b0;
`endif

   assign bus.shc_ps_rdy   = rdy_s;
   assign bus.ps_shf_en    = iss_r.valid;
   assign bus.ps_shf_cls   = iss_r.cls;
   assign bus.shc_rf_rxa   = iss_r.rx;
   assign bus.shc_rf_rya   = iss_r.ry;
   assign bus.shc_rf_we    = we_r;
   assign bus.shc_rf_wa    = wa_r;
   assign bus.shc_ill      = ill_r;
   assign bus.shc_astat_sz = astat_sz_r;
   assign bus.shc_astat_sv = astat_sv_r;

endmodule

// File: tb/tb_shf_ctl.sv
// Bench for shf_ctl: directed cycle table followed by randomized traffic
// checked against a cycle-timeline reference model.
module tb_shf_ctl;

   localparam int NROWS = 19;
   localparam int NR    = 800;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   shf_ctl_if bus_if ();

   shf_ctl u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [15:0] ins;
      logic        sv;
      logic        sz;
      logic        clr;
      logic [20:0] exp_ns;
      logic        svs_st;
   } row_t;

   row_t rows [NROWS];

   // Expected vector without the sticky bit: rdy,en,cls,rxa,rya,we,wa,ill,asz,asv
   function automatic logic [20:0] pk(input logic rdy, input logic en, input logic [1:0] cls,
                                      input logic [3:0] rxa, input logic [3:0] rya, input logic we,
                                      input logic [3:0] wa, input logic ill, input logic asz,
                                      input logic asv, input logic asvs);
      return {rdy, en, cls, rxa, rya, we, wa, ill, asz, asv, asvs};
   endfunction

   function automatic row_t mk(input logic rst, input logic vld, input logic [15:0] ins,
                               input logic sv, input logic sz, input logic clr,
                               input logic rdy, input logic en, input logic [1:0] cls,
                               input logic [3:0] rxa, input logic [3:0] rya, input logic we,
                               input logic [3:0] wa, input logic ill, input logic asz,
                               input logic asv, input logic svs_st);
      row_t r;
      r.rst    = rst;
      r.vld    = vld;
      r.ins    = ins;
      r.sv     = sv;
      r.sz     = sz;
      r.clr    = clr;
      r.exp_ns = pk(rdy, en, cls, rxa, rya, we, wa, ill, asz, asv, 1'b0);
      r.svs_st = svs_st;
      return r;
   endfunction

   function automatic logic [20:0] observe();
      return pk(bus_if.shc_ps_rdy, bus_if.ps_shf_en, bus_if.ps_shf_cls, bus_if.shc_rf_rxa,
                bus_if.shc_rf_rya, bus_if.shc_rf_we, bus_if.shc_rf_wa, bus_if.shc_ill,
                bus_if.shc_astat_sz, bus_if.shc_astat_sv, bus_if.shc_astat_svs);
   endfunction

   task automatic drive(input logic rst, input logic vld, input logic [15:0] ins,
                        input logic sv, input logic sz, input logic clr);
      reset               = rst;
      bus_if.ps_ins_vld   = vld;
      bus_if.ps_ins       = ins;
      bus_if.shf_ps_sv    = sv;
      bus_if.shf_ps_sz    = sz;
      bus_if.ps_astat_clr = clr;
   endtask

   task automatic check(input string name, input int idx, input logic [20:0] exp);
      logic [20:0] got;
      got = observe();
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s[%0d]: got %h expected %h (rdy,en,cls,rxa,rya,we,wa,ill,sz,sv,svs)",
                  name, idx, got, exp);
      end
   endtask

   // Reference model: per-cycle timeline of scheduled outputs.
   logic       m_en  [NR+4];
   logic [1:0] m_cls [NR+4];
   logic [3:0] m_rxa [NR+4];
   logic [3:0] m_rya [NR+4];
   logic [3:0] m_rn  [NR+4];
   logic       m_we  [NR+4];
   logic [3:0] m_wa  [NR+4];
   logic       m_ill [NR+4];

   initial begin
      logic [20:0] e;
      logic        a_sz, a_sv, a_svs;
      logic        rst, vld, sv, sz, clr, rdy, haz, acc;
      logic [1:0]  g, c;
      logic [3:0]  rn, rx, ry;
      logic [15:0] ins;

      n_cmp = 0;
      n_bad = 0;
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

      //            rst  vld   ins       sv   sz   clr   rdy  en   cls    rxa    rya    we   wa     ill  asz  asv  svs
      rows[0]  = mk(1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,4'd0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0);
      rows[1]  = mk(1'b0,1'b1,16'h8312,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,4'd0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0);
      rows[2]  = mk(1'b1,1'b1,16'h8312,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,4'd0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0);
      rows[3]  = mk(1'b1,1'b1,16'h9632,1'b0,1'b0,1'b0, 1'b0,1'b1,2'd0,4'd1,4'd2,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0);
      rows[4]  = mk(1'b1,1'b1,16'h9632,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,4'd0,4'd0,1'b1,4'd3,1'b0,1'b0,1'b0,1'b0);
      rows[5]  = mk(1'b1,1'b1,16'hB785,1'b0,1'b0,1'b0, 1'b1,1'b1,2'd1,4'd3,4'd2,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0);
      rows[6]  = mk(1'b1,1'b1,16'hA980,1'b1,1'b1,1'b0, 1'b1,1'b1,2'd3,4'd8,4'd0,1'b1,4'd6,1'b0,1'b0,1'b0,1'b0);
      rows[7]  = mk(1'b1,1'b1,16'h4123,1'b0,1'b0,1'b0, 1'b1,1'b1,2'd2,4'd8,4'd0,1'b1,4'd7,1'b0,1'b1,1'b1,1'b1);
      rows[8]  = mk(1'b1,1'b0,16'h0000,1'b1,1'b0,1'b1, 1'b1,1'b0,2'd0,4'd0,4'd0,1'b1,4'd9,1'b1,1'b0,1'b0,1'b1);
      rows[9]  = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1, 1'b1,1'b0,2'd0,4'd0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b1,1'b1);
      rows[10] = mk(1'b1,1'b1,16'h8312,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,4'd0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b1,1'b0);
      rows[11] = mk(1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b1,2'd0,4'd1,4'd2,1'b0,4'd0,1'b0,1'b0,1'b1,1'b0);
      rows[12] = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,4'd0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0);
      rows[13] = mk(1'b1,1'b1,16'h8512,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,4'd0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0);
      rows[14] = mk(1'b1,1'b1,16'h8415,1'b0,1'b0,1'b0, 1'b0,1'b1,2'd0,4'd1,4'd2,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0);
      rows[15] = mk(1'b1,1'b1,16'h8415,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,4'd0,4'd0,1'b1,4'd5,1'b0,1'b0,1'b0,1'b0);
      rows[16] = mk(1'b1,1'b1,16'hA314,1'b0,1'b0,1'b0, 1'b1,1'b1,2'd0,4'd1,4'd5,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0);
      rows[17] = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b1,1'b1,2'd2,4'd1,4'd0,1'b1,4'd4,1'b0,1'b0,1'b0,1'b0);
      rows[18] = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,4'd0,4'd0,1'b1,4'd3,1'b0,1'b0,1'b0,1'b0);

      for (int i = 0; i < NROWS; i++) begin
         @(negedge clk);
         drive(rows[i].rst, rows[i].vld, rows[i].ins, rows[i].sv, rows[i].sz, rows[i].clr);
         #1;
         e = rows[i].exp_ns;
`ifdef SHF_STICKY_EN
         e[0] = rows[i].svs_st;
`endif
         check("dir", i, e);
      end

      // Random phase starts from a freshly reset pipeline.
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      for (int t = 0; t < NR + 4; t++) begin
         m_en[t] = 1'b0; m_cls[t] = 2'd0; m_rxa[t] = 4'd0; m_rya[t] = 4'd0;
         m_rn[t] = 4'd0; m_we[t] = 1'b0;  m_wa[t] = 4'd0;  m_ill[t] = 1'b0;
      end
      a_sz = 1'b0; a_sv = 1'b0; a_svs = 1'b0;

      for (int t = 0; t < NR; t++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 39) != 0);
         vld = ($urandom_range(0, 3) != 0);
         g   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
         c   = 2'($urandom_range(0, 3));
         rn  = 4'($urandom_range(0, 3));
         rx  = 4'($urandom_range(0, 3));
         ry  = 4'($urandom_range(0, 3));
         ins = {g, c, rn, rx, ry};
         sv  = 1'($urandom_range(0, 1));
         sz  = 1'($urandom_range(0, 1));
         clr = ($urandom_range(0, 7) == 0);
         drive(rst, vld, ins, sv, sz, clr);
         #1;

         haz = vld && (g == 2'b10) && m_en[t] &&
               ((rx == m_rn[t]) || ((c[1] == 1'b0) && (ry == m_rn[t])));
         rdy = rst && !haz;
         check("rnd", t, pk(rdy, m_en[t], m_cls[t], m_rxa[t], m_rya[t], m_we[t], m_wa[t],
                            m_ill[t], a_sz, a_sv, a_svs));

         if (!rst) begin
            m_en[t+1] = 1'b0; m_cls[t+1] = 2'd0; m_rxa[t+1] = 4'd0; m_rya[t+1] = 4'd0;
            m_rn[t+1] = 4'd0; m_we[t+1]  = 1'b0; m_wa[t+1]  = 4'd0; m_ill[t+1] = 1'b0;
            a_sz = 1'b0; a_sv = 1'b0; a_svs = 1'b0;
         end else begin
            acc = vld && rdy;
            if (acc && (g == 2'b10)) begin
               m_en[t+1]  = 1'b1;
               m_cls[t+1] = c;
               m_rxa[t+1] = rx;
               m_rya[t+1] = c[1] ? 4'd0 : ry;
               m_rn[t+1]  = rn;
               m_we[t+2]  = 1'b1;
               m_wa[t+2]  = rn;
            end
            if (acc && (g != 2'b10)) m_ill[t+1] = 1'b1;
`ifdef SHF_STICKY_EN
            if (m_we[t] && sv) a_svs = 1'b1;
            else if (clr)      a_svs = 1'b0;
`endif
            if (m_we[t]) begin
               a_sz = sz;
               a_sv = sv;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
